// File: rtl/regfile_pkg.sv
// Shared types and helpers for the clocked register file: write-extension modes
// and the legality check used by the extension stage.
package regfile_pkg;

  localparam int WM_W = 3;

  typedef enum logic [WM_W-1:0] {
    WM_WORD   = 3'd0,
    WM_BYTE_U = 3'd1,
    WM_HALF_U = 3'd2,
    WM_BYTE_S = 3'd3,
    WM_HALF_S = 3'd4
  } wr_mode_e;

  // Codes 5-7 are reserved and must never reach the array.
  function automatic logic mode_is_legal(input logic [WM_W-1:0] mode);
    return mode <= WM_HALF_S;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback bus of the register file: read ports, write port and load scoreboard.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [WM_W-1:0]          wr_mode;
  logic                     wr_err;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_addr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mode, busy_set, busy_addr,
    input  rd_data, rd_valid, rd_busy, wr_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mode, busy_set, busy_addr,
    output rd_data, rd_valid, rd_busy, wr_err
  );

endinterface

// File: rtl/load_extend.sv
// Combinational sub-word extension of writeback data ahead of the register write.
module load_extend
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] wr_data,
  input  logic [WM_W-1:0]   wr_mode,
  output logic [DATA_W-1:0] ext_data,
  output logic              legal
);

  assign legal = mode_is_legal(wr_mode);

  always_comb begin
    ext_data = wr_data;
    case (wr_mode)
      WM_WORD:   ext_data = wr_data;
      WM_BYTE_U: ext_data = {{(DATA_W-8){1'b0}}, wr_data[7:0]};
      WM_HALF_U: ext_data = {{(DATA_W-16){1'b0}}, wr_data[15:0]};
      WM_BYTE_S: ext_data = {{(DATA_W-8){wr_data[7]}}, wr_data[7:0]};
      WM_HALF_S: ext_data = {{(DATA_W-16){wr_data[15]}}, wr_data[15:0]};
      default:   ext_data = wr_data;
    endcase
  end

endmodule

// File: rtl/regfile_sync.sv
// Clocked register file: registered read ports with write bypass, one extending
// write port and a per-register pending-load scoreboard. Register 0 reads as zero.
module regfile_sync
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  regfile_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  // Address decode as a lookup so non-power-of-two NUM_REGS needs no range compare.
  function automatic logic [DEPTH-1:0] make_addr_ok();
    logic [DEPTH-1:0] m;
    for (int r = 0; r < DEPTH; r++) m[r] = (r < NUM_REGS);
    return m;
  endfunction

  localparam logic [DEPTH-1:0] ADDR_OK = make_addr_ok();

  logic [DATA_W-1:0] regs_p0 [DEPTH];
  logic [DEPTH-1:0]  busy_p0;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] ext_data;
  logic              legal;
  logic              wr_commit;
  logic              wr_bad;
  logic              busy_ok;
  logic              wr_err_p1;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .wr_data  (bus.wr_data),
    .wr_mode  (bus.wr_mode),
    .ext_data (ext_data),
    .legal    (legal)
  );

  assign wr_commit = bus.wr_en && legal && (bus.wr_addr != '0) && ADDR_OK[bus.wr_addr];
  assign wr_bad    = bus.wr_en && (!legal || !ADDR_OK[bus.wr_addr]);
  assign busy_ok   = bus.busy_set && (bus.busy_addr != '0) && ADDR_OK[bus.busy_addr];

  // Set is applied after clear so a simultaneous set/clear leaves the register busy.
  always_comb begin
    busy_nxt = busy_p0;
    if (wr_commit) busy_nxt[bus.wr_addr] = 1'b0;
    if (busy_ok)   busy_nxt[bus.busy_addr] = 1'b1;
  end

  // ---- stage p0 -> array / scoreboard state ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs_p0[r] <= '0;
      busy_p0   <= '0;
      wr_err_p1 <= 1'b0;
    end else begin
      if (wr_commit) regs_p0[bus.wr_addr] <= ext_data;
      busy_p0   <= busy_nxt;
      wr_err_p1 <= wr_bad;
    end
  end

  assign bus.wr_err = wr_err_p1;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_p0;
    logic              hit_p0;
    logic [DATA_W-1:0] data_p0;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              busy_p1;

    assign addr_p0 = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign hit_p0  = (addr_p0 != '0) && ADDR_OK[addr_p0];

    always_comb begin
      data_p0 = '0;
      if (hit_p0)
        data_p0 = (wr_commit && (bus.wr_addr == addr_p0)) ? ext_data : regs_p0[addr_p0];
    end

    // ---- stage p0 -> p1: registered read result ----
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_p1 <= '0;
        vld_p1  <= 1'b0;
        busy_p1 <= 1'b0;
      end else begin
        vld_p1 <= bus.rd_en[i];
        if (bus.rd_en[i]) begin
          data_p1 <= data_p0;
          busy_p1 <= hit_p0 && busy_nxt[addr_p0];
        end
      end
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = data_p1;
    assign bus.rd_valid[i]                 = vld_p1;
    assign bus.rd_busy[i]                  = busy_p1;
  end

endmodule

// File: tb/tb_regfile_sync.sv
// Self-checking bench for regfile_sync: directed scenarios plus randomized traffic
// compared each cycle against an array-based reference model.
module tb_regfile_sync;
  import regfile_pkg::*;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;

  logic clk;
  logic rst_n;

  regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_sync #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic              m_busy [NUM_REGS];
  logic [DATA_W-1:0] exp_data  [NUM_RD];
  logic              exp_valid [NUM_RD];
  logic              exp_busy  [NUM_RD];
  logic              exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [31:0] d, input int mode);
    logic [31:0] b, h;
    b = d % 256;
    h = d % 65536;
    case (mode)
      0: return d;
      1: return b;
      2: return h;
      3: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      default: return d;
    endcase
  endfunction

  // Updates architectural state first, then reads it: this gives bypass and
  // post-update busy naturally.
  task automatic model_edge();
    int wa, ba, ra, mode;
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      for (int i = 0; i < NUM_RD; i++) begin
        exp_data[i] = '0; exp_valid[i] = 1'b0; exp_busy[i] = 1'b0;
      end
      exp_err = 1'b0;
      return;
    end
    wa   = int'(bus.wr_addr);
    ba   = int'(bus.busy_addr);
    mode = int'(bus.wr_mode);
    exp_err = bus.wr_en && (mode > 4 || wa >= NUM_REGS);
    if (bus.wr_en && mode <= 4 && wa < NUM_REGS && wa != 0) begin
      m_regs[wa] = model_ext(bus.wr_data, mode);
      m_busy[wa] = 1'b0;
    end
    if (bus.busy_set && ba != 0 && ba < NUM_REGS) m_busy[ba] = 1'b1;
    for (int i = 0; i < NUM_RD; i++) begin
      exp_valid[i] = bus.rd_en[i];
      if (bus.rd_en[i]) begin
        ra = int'(bus.rd_addr[i*ADDR_W +: ADDR_W]);
        exp_data[i] = (ra < NUM_REGS && ra != 0) ? m_regs[ra] : '0;
        exp_busy[i] = (ra < NUM_REGS && ra != 0) ? m_busy[ra] : 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("wr_err", 64'(bus.wr_err), 64'(exp_err));
    for (int i = 0; i < NUM_RD; i++) begin
      check($sformatf("rd_valid[%0d]", i), 64'(bus.rd_valid[i]), 64'(exp_valid[i]));
      check($sformatf("rd_data[%0d]", i), 64'(bus.rd_data[i*DATA_W +: DATA_W]), 64'(exp_data[i]));
      check($sformatf("rd_busy[%0d]", i), 64'(bus.rd_busy[i]), 64'(exp_busy[i]));
    end
  endtask

  task automatic idle();
    bus.rd_en = '0; bus.rd_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mode = '0;
    bus.busy_set = 1'b0; bus.busy_addr = '0;
  endtask

  task automatic set_write(input int a, input logic [31:0] d, input int mode);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = d; bus.wr_mode = WM_W'(mode);
  endtask

  task automatic set_read(input int a0, input int a1, input logic [1:0] en);
    bus.rd_en = en;
    bus.rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  logic [31:0] mode_exp [4];
  int          mode_seq [4];

  initial begin
    mode_seq[0] = 1; mode_exp[0] = 32'h0000_006B;
    mode_seq[1] = 4; mode_exp[1] = 32'hFFFF_B06B;
    mode_seq[2] = 2; mode_exp[2] = 32'h0000_B06B;
    mode_seq[3] = 3; mode_exp[3] = 32'h0000_006B;

    idle();
    rst_n = 1'b0;
    cycle();
    // Write and busy_set presented during reset must be discarded.
    set_write(5, 32'hAAAA_5555, 0);
    bus.busy_set = 1'b1; bus.busy_addr = 5'd5;
    cycle();
    check("reset_valid", 64'(bus.rd_valid), 64'(0));
    check("reset_err", 64'(bus.wr_err), 64'(0));
    rst_n = 1'b1;
    idle();

    set_read(0, 5, 2'b11);
    cycle();
    check("r0_r5_data", 64'(bus.rd_data), 64'(0));
    check("r0_r5_valid", 64'(bus.rd_valid), 64'(2'b11));
    check("r0_r5_busy", 64'(bus.rd_busy), 64'(2'b00));
    idle();

    for (int k = 0; k < 4; k++) begin
      set_write(14, 32'h0054_B06B, mode_seq[k]);
      cycle();
      idle();
      set_read(14, 0, 2'b01);
      cycle();
      check($sformatf("ext_mode%0d", mode_seq[k]), 64'(bus.rd_data[31:0]), 64'(mode_exp[k]));
      idle();
    end

    set_write(0, 32'hDEAD_BEEF, 0);
    cycle();
    check("r0_write_err", 64'(bus.wr_err), 64'(0));
    idle();
    set_read(0, 0, 2'b01);
    cycle();
    check("r0_reads_zero", 64'(bus.rd_data[31:0]), 64'(0));
    idle();
    set_write(14, 32'h1234_5678, 6);
    cycle();
    check("reserved_err", 64'(bus.wr_err), 64'(1));
    idle();
    set_read(14, 0, 2'b01);
    cycle();
    check("reserved_err_pulse", 64'(bus.wr_err), 64'(0));
    check("reserved_no_write", 64'(bus.rd_data[31:0]), 64'(32'h6B));
    idle();

    set_write(7, 32'h1234, 0);
    set_read(7, 7, 2'b11);
    cycle();
    check("bypass_p0", 64'(bus.rd_data[31:0]), 64'(32'h1234));
    check("bypass_p1", 64'(bus.rd_data[63:32]), 64'(32'h1234));
    idle();

    bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
    cycle();
    idle();
    set_read(9, 0, 2'b01);
    cycle();
    check("busy_r9", 64'(bus.rd_busy[0]), 64'(1));
    idle();
    set_write(9, 32'h55, 0);
    set_read(9, 0, 2'b01);
    cycle();
    check("clear_r9_data", 64'(bus.rd_data[31:0]), 64'(32'h55));
    check("clear_r9_busy", 64'(bus.rd_busy[0]), 64'(0));
    idle();

    set_write(3, 32'h77, 0);
    bus.busy_set = 1'b1; bus.busy_addr = 5'd3;
    cycle();
    idle();
    set_read(3, 0, 2'b01);
    cycle();
    check("set_wins_r3", 64'(bus.rd_busy[0]), 64'(1));
    idle();

    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int r = 0; r < NUM_REGS / 2; r++) begin
      set_read(r, r + NUM_REGS / 2, 2'b11);
      cycle();
      check("post_reset_data", 64'(bus.rd_data), 64'(0));
      check("post_reset_busy", 64'(bus.rd_busy), 64'(0));
    end
    idle();

    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.rd_en     = NUM_RD'($urandom());
      bus.rd_addr   = (NUM_RD*ADDR_W)'($urandom());
      bus.wr_en     = ($urandom_range(0, 2) != 0);
      bus.wr_addr   = ADDR_W'($urandom());
      bus.wr_data   = $urandom();
      bus.wr_mode   = WM_W'($urandom_range(0, 7));
      bus.busy_set  = ($urandom_range(0, 2) == 0);
      bus.busy_addr = ADDR_W'($urandom());
      // Bias toward address collisions to exercise bypass and set/clear ordering.
      if ($urandom_range(0, 3) == 0) bus.rd_addr = {bus.wr_addr, bus.wr_addr};
      if ($urandom_range(0, 3) == 0) bus.busy_addr = bus.wr_addr;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sync.md
Name: regfile_sync

Overview:
- Clocked, parametrised successor to the single-cycle MIPS register file.
- Provides NUM_RD registered read ports and one write port with byte/half/word extension modes (signed and unsigned).
- Includes write-to-read bypass and a per-register pending-load scoreboard.
- Sits between decode (read addresses) and writeback (load/ALU results).

Parameters:
- DATA_W, 32, register width in bits; must be ≥16 and a multiple of 8.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- ADDR_W, $clog2(NUM_REGS), register address width.
- NUM_RD, 2, number of independent read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, registered.
- rd_valid  out  NUM_RD  per-port: rd_data is valid this cycle.
- rd_busy  out  NUM_RD  per-port: register read was pending a load when sampled.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write destination.
- wr_data  in  DATA_W  raw write data; low bits are used for sub-word modes.
- wr_mode  in  3  0 WORD, 1 BYTE_U, 2 HALF_U, 3 BYTE_S, 4 HALF_S; 5–7 reserved.
- wr_err  out  1  one-cycle pulse for a write with a reserved mode or an out-of-range address.
- busy_set  in  1  mark busy_addr as pending load.
- busy_addr  in  ADDR_W  register to mark.

Behaviour:
- All sequential logic uses posedge clk. Reset is checked only at the edge: rst_n=0 at an edge clears state.
- Reset values:
  - all registers = 0;
  - all busy bits = 0;
  - rd_data = 0, rd_valid = 0, rd_busy = 0;
  - wr_err = 0.
- Reset mid-operation: a write or busy_set presented in the reset cycle is discarded.
- Write extension (combinational, ahead of the write):
  - WORD: full wr_data.
  - BYTE_U: zero-extend wr_data[7:0].
  - HALF_U: zero-extend wr_data[15:0].
  - BYTE_S: sign-extend from bit 7.
  - HALF_S: sign-extend from bit 15.
- Write commits at the edge when wr_en=1, the mode is legal, wr_addr ≠ 0 and wr_addr < NUM_REGS.
  - Write to address 0: silently dropped; no wr_err.
  - Reserved mode or wr_addr ≥ NUM_REGS: no write; wr_err=1 for exactly the next cycle.
- Read latency is 1 cycle. If rd_en[i] at edge N:
  - rd_data[i] = register value, rd_valid[i] = 1, during cycle N+1;
  - otherwise rd_valid[i] = 0 and rd_data[i] holds its previous value.
- Address 0 always reads 0. Address ≥ NUM_REGS reads 0 with rd_busy = 0.
- Bypass: when a read and a committing write target the same nonzero address at the same edge, rd_data returns the newly written, extended value. Ports resolve independently; several ports may read the same address.
- Scoreboard (one busy bit per register):
  - busy_set=1 sets busy[busy_addr];
  - a committing write clears busy[wr_addr];
  - same edge, same address for both: set wins, so busy ends at 1;
  - busy_set on address 0 or out of range is ignored;
  - busy_set on an already-busy register leaves it busy.
- rd_busy[i] is sampled with rd_data and uses the post-update busy value for the same edge. A read that coincides with the clearing write therefore reports busy = 0.
- No stall generation; consumers act on rd_busy.

Decomposition:
- Package regfile_pkg:
  - wr_mode enum: WM_WORD, WM_BYTE_U, WM_HALF_U, WM_BYTE_S, WM_HALF_S;
  - function mode_is_legal.
- Sub-module load_extend, combinational: (wr_data, wr_mode) → ext_data, legal.
- Read ports are generated with a for-generate over NUM_RD.

Test Plan:
- Reset, then read r0 and r5 → rd_data = 0/0, rd_valid = 11 one cycle later, rd_busy = 00.
- Write r14 with 0x0054_B06B in each mode, then read it:
  - BYTE_U → 0x0000_006B;
  - HALF_S → 0xFFFF_B06B;
  - HALF_U → 0x0000_B06B;
  - BYTE_S → 0x0000_006B.
- Write r0 WORD 0xDEADBEEF, then read r0 → 0; wr_err stays 0. Write wr_mode = 6 → wr_err pulses 1 cycle and the target register is unchanged.
- Same edge: write r7 = 0x1234 and read r7 on both ports → both ports return 0x0000_1234 the next cycle.
- busy_set r9, then read r9 → rd_busy = 1. Then, at the same edge, write r9 WORD 0x55 and read r9 → rd_data = 0x55, rd_busy = 0.
- Same edge busy_set r3 and write r3 → a later read of r3 shows rd_busy = 1. Assert rst_n=0 for one cycle → all registers and busy bits read back 0.
